axi_burst_write_master: RTL and testbench

- Parametrised AXI write-DMA master, the next generation of the fixed 32-bit, 16-beat master port.
- Accepts a write command (start address, beat count) and a data stream, then emits INCR bursts on an AXI write channel set.
- Generalised in data width and max burst length; adds 4KB-boundary splitting, multiple outstanding bursts, and a sticky error status.
- Sits between core-side FIFO logic and the PS/HP interconnect port.

---
 rtl/axi_burst_write_master.sv | 195 +++++++++++++++++++
 tb/tb_axi_burst_write_master.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_write_master.sv
// AXI4 write-DMA master: turns a (start address, beat count) command plus a data stream
// into INCR bursts that never cross a 4KB boundary, with several bursts in flight.
module axi_burst_write_master #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_MAX_BURST_LEN    = 16,
    parameter int unsigned C_LEN_WIDTH        = 20,
    parameter int unsigned C_MAX_OUTSTANDING  = 4
) (
    input  logic                            m_axi_aclk,
    input  logic                            m_axi_areset,

    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_LEN_WIDTH-1:0]          cmd_beats,

    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   s_data,

    output logic                            done,
    output logic                            error,
    output logic                            busy,

    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                      m_axi_awlen,
    output logic [2:0]                      m_axi_awsize,
    output logic [1:0]                      m_axi_awburst,
    output logic [2:0]                      m_axi_awprot,
    output logic [3:0]                      m_axi_awcache,

    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                            m_axi_wlast,

    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready,
    input  logic [1:0]                      m_axi_bresp
);

    localparam int unsigned SizeLog2 = $clog2(C_M_AXI_DATA_WIDTH / 8);
    localparam logic [3:0]  MaxOut   = 4'(C_MAX_OUTSTANDING);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StAddr  = 2'd1;
    localparam logic [1:0] StData  = 2'd2;
    localparam logic [1:0] StDrain = 2'd3;

    logic [1:0]                    state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;
    logic [C_LEN_WIDTH-1:0]        remaining_q;
    logic [3:0]                    outstanding_q;
    logic [8:0]                    beat_q;
    logic [8:0]                    len_q;
    logic                          error_q;
    logic                          busy_q;
    logic                          done_q;

    logic        cmd_accept;
    logic        aw_fire;
    logic        w_fire;
    logic        b_fire;
    logic        last_beat;
    logic [3:0]  outstanding_after_b;
    logic [12:0] to_boundary;
    logic [8:0]  rem_cap;
    logic [8:0]  burst_len;

    assign cmd_accept = cmd_valid && cmd_ready;
    assign aw_fire    = m_axi_awvalid && m_axi_awready;
    assign w_fire     = m_axi_wvalid && m_axi_wready;
    assign b_fire     = m_axi_bvalid;
    assign last_beat  = (beat_q == len_q - 9'd1);

    // Look through a B arriving this cycle so done trails the final response by one cycle.
    assign outstanding_after_b = outstanding_q - ((b_fire && outstanding_q != 4'd0) ? 4'd1 : 4'd0);

    // Burst length: min(remaining, max burst, beats left before the next 4KB page).
    always_comb begin
        to_boundary = (13'h1000 - {1'b0, addr_q[11:0]}) >> SizeLog2;
        rem_cap     = (remaining_q > C_LEN_WIDTH'(C_MAX_BURST_LEN)) ? 9'(C_MAX_BURST_LEN)
                                                                     : remaining_q[8:0];
        burst_len   = ({4'b0, rem_cap} < to_boundary) ? rem_cap : to_boundary[8:0];
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_accept) begin
                    state_d = (cmd_beats == '0) ? StDrain : StAddr;
                end
            end
            StAddr: begin
                if (aw_fire) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (w_fire && last_beat) begin
                    state_d = (remaining_q == C_LEN_WIDTH'(len_q)) ? StDrain : StAddr;
                end
            end
            StDrain: begin
                if (outstanding_after_b == 4'd0) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            remaining_q   <= '0;
            outstanding_q <= '0;
            beat_q        <= '0;
            len_q         <= '0;
            error_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;

            if (cmd_accept) begin
                addr_q      <= cmd_addr;
                remaining_q <= cmd_beats;
                busy_q      <= 1'b1;
            end

            if (aw_fire) begin
                len_q  <= burst_len;
                beat_q <= '0;
            end

            if (w_fire) begin
                if (last_beat) begin
                    beat_q      <= '0;
                    addr_q      <= addr_q + (C_M_AXI_ADDR_WIDTH'(len_q) << SizeLog2);
                    remaining_q <= remaining_q - C_LEN_WIDTH'(len_q);
                end else begin
                    beat_q <= beat_q + 9'd1;
                end
            end

            if (state_q == StDrain && outstanding_after_b == 4'd0) begin
                done_q <= 1'b1;
                busy_q <= 1'b0;
            end

            // A simultaneous AW issue and B retire cancel out.
            if (aw_fire && !b_fire) begin
                outstanding_q <= outstanding_q + 4'd1;
            end else if (!aw_fire && b_fire && outstanding_q != 4'd0) begin
                outstanding_q <= outstanding_q - 4'd1;
            end

            if (cmd_accept) begin
                error_q <= 1'b0;
            end else if (b_fire && m_axi_bresp != 2'b00) begin
                error_q <= 1'b1;
            end
        end
    end

    assign cmd_ready = (state_q == StIdle) && !m_axi_areset;
    assign done      = done_q;
    assign error     = error_q;
    assign busy      = busy_q;

    assign m_axi_awvalid = (state_q == StAddr) && (outstanding_q < MaxOut);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = 8'(burst_len - 9'd1);
    assign m_axi_awsize  = 3'(SizeLog2);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awcache = 4'b0011;

    assign m_axi_wvalid = (state_q == StData) && s_valid;
    assign s_ready      = (state_q == StData) && m_axi_wready;
    assign m_axi_wdata  = s_data;
    assign m_axi_wstrb  = '1;
    assign m_axi_wlast  = (state_q == StData) && last_beat;

    assign m_axi_bready = 1'b1;

endmodule

// File: tb/tb_axi_burst_write_master.sv
// Bench for axi_burst_write_master: a transaction-level model (burst plan, beat/burst/B counts)
// is checked against the DUT on every cycle, plus literal checks on logged AW/W/B events.
module tb_axi_burst_write_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 20;
    localparam int MAXB = 16;
    localparam int MAXO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          cmd_valid, cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_beats;
    logic          s_valid, s_ready;
    logic [DW-1:0] s_data;
    logic          done, error, busy;
    logic          awvalid, awready;
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic [2:0]    awsize, awprot;
    logic [1:0]    awburst;
    logic [3:0]    awcache;
    logic          wvalid, wready, wlast;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] wstrb;
    logic          bvalid, bready;
    logic [1:0]    bresp;

    axi_burst_write_master #(
        .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW), .C_MAX_BURST_LEN(MAXB),
        .C_LEN_WIDTH(LW), .C_MAX_OUTSTANDING(MAXO)
    ) dut (
        .m_axi_aclk(clk), .m_axi_areset(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .done(done), .error(error), .busy(busy),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
        .m_axi_awlen(awlen), .m_axi_awsize(awsize), .m_axi_awburst(awburst),
        .m_axi_awprot(awprot), .m_axi_awcache(awcache),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata),
        .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input longint unsigned got, input longint unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pattern(input int i);
        return 32'hD000_0000 + 32'(i) * 32'd7;
    endfunction

    // Bench configuration, written only by the sequence process.
    bit hold_b = 1'b0;
    bit rand_mode = 1'b0;
    int err_burst = -1;

    // Model state, written only by the cycle process.
    logic [31:0] pl_addr[64];
    int  pl_len[64];
    int  n_bursts, aw_cnt, wl_cnt, b_cnt, beat_in;
    bit  active, zero_stage, exp_done, exp_busy, exp_error, nd, exp_awv, dphase;
    int  src_idx, w_idx, rst_cnt, cyc;
    logic [31:0] log_aw_addr[64];
    int  log_aw_len[64];
    int  log_n, log_wl_pos[64], log_wl_n, w_beats, acc_cyc, done_cyc, lastb_cyc, busy_cycles;

    // Expected burst split: min(remaining, max burst, beats to next 4KB page).
    task automatic plan(input logic [31:0] a_in, input int beats_in);
        logic [31:0] a;
        int beats;
        a = a_in;
        beats = beats_in;
        n_bursts = 0;
        while (beats > 0) begin
            int to_page;
            int l;
            to_page = (4096 - int'(a[11:0])) / (DW / 8);
            l = beats;
            if (l > MAXB) l = MAXB;
            if (l > to_page) l = to_page;
            pl_addr[n_bursts] = a;
            pl_len[n_bursts] = l - 1;
            n_bursts++;
            a = a + 32'(l * (DW / 8));
            beats = beats - l;
        end
    endtask

    // Cycle process: check at negedge, update the model, then drive the slave and source.
    initial begin
        n_bursts = 0; aw_cnt = 0; wl_cnt = 0; b_cnt = 0; beat_in = 0;
        active = 0; zero_stage = 0; exp_done = 0; exp_busy = 0; exp_error = 0;
        src_idx = 0; w_idx = 0; rst_cnt = 0; cyc = 0;
        log_n = 0; log_wl_n = 0; w_beats = 0; acc_cyc = 0; done_cyc = 0; lastb_cyc = 0;
        busy_cycles = 0;
        awready = 0; wready = 0; s_valid = 0; s_data = pattern(0); bvalid = 0; bresp = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                rst_cnt++;
                if (rst_cnt >= 2) begin
                    chk("rst_awvalid", 64'(awvalid), 0);
                    chk("rst_wvalid", 64'(wvalid), 0);
                    chk("rst_wlast", 64'(wlast), 0);
                    chk("rst_done", 64'(done), 0);
                    chk("rst_busy", 64'(busy), 0);
                    chk("rst_error", 64'(error), 0);
                    chk("rst_cmd_ready", 64'(cmd_ready), 0);
                    chk("rst_s_ready", 64'(s_ready), 0);
                end
                active = 0; n_bursts = 0; aw_cnt = 0; wl_cnt = 0; b_cnt = 0; beat_in = 0;
                zero_stage = 0; exp_done = 0; exp_busy = 0; exp_error = 0;
                w_idx = src_idx;
            end else begin
                rst_cnt = 0;
                chk("cmd_ready", 64'(cmd_ready), 64'(!exp_busy));
                chk("busy", 64'(busy), 64'(exp_busy));
                chk("done", 64'(done), 64'(exp_done));
                chk("error", 64'(error), 64'(exp_error));
                exp_awv = active && aw_cnt < n_bursts && aw_cnt == wl_cnt &&
                          (aw_cnt - b_cnt) < MAXO;
                chk("awvalid", 64'(awvalid), 64'(exp_awv));
                if (awvalid && exp_awv) begin
                    chk("awaddr", 64'(awaddr), 64'(pl_addr[aw_cnt]));
                    chk("awlen", 64'(awlen), 64'(pl_len[aw_cnt]));
                    chk("aw_const", {41'd0, awsize, awburst, awprot, awcache, wstrb, bready},
                        {41'd0, 3'd2, 2'b01, 3'b000, 4'b0011, 4'hF, 1'b1});
                end
                dphase = active && aw_cnt > wl_cnt;
                chk("wvalid", 64'(wvalid), 64'(dphase && s_valid));
                chk("s_ready", 64'(s_ready), 64'(dphase && wready));
                if (wvalid && dphase) begin
                    chk("wdata", 64'(wdata), 64'(pattern(w_idx)));
                    chk("wlast", 64'(wlast), 64'(beat_in == pl_len[wl_cnt]));
                end

                // Model update from this cycle's handshakes.
                nd = 0;
                if (done) done_cyc = cyc;
                if (busy) busy_cycles++;
                if (zero_stage) begin
                    nd = 1;
                    zero_stage = 0;
                end
                if (cmd_valid && cmd_ready) begin
                    plan(cmd_addr, int'(cmd_beats));
                    active = 1; aw_cnt = 0; wl_cnt = 0; b_cnt = 0; beat_in = 0;
                    exp_error = 0;
                    zero_stage = (cmd_beats == '0);
                    acc_cyc = cyc; log_n = 0; log_wl_n = 0; w_beats = 0; busy_cycles = 0;
                end
                if (awvalid && awready) begin
                    if (log_n < 64) begin
                        log_aw_addr[log_n] = awaddr;
                        log_aw_len[log_n] = int'(awlen);
                        log_n++;
                    end
                    aw_cnt++;
                end
                if (s_valid && s_ready) src_idx++;
                if (wvalid && wready) begin
                    w_idx++;
                    w_beats++;
                    if (wlast && log_wl_n < 64) begin
                        log_wl_pos[log_wl_n] = w_beats;
                        log_wl_n++;
                    end
                    if (dphase) begin
                        if (beat_in == pl_len[wl_cnt]) begin
                            wl_cnt++;
                            beat_in = 0;
                        end else begin
                            beat_in++;
                        end
                    end
                end
                if (bvalid) begin
                    lastb_cyc = cyc;
                    if (bresp != 2'b00) exp_error = 1;
                    b_cnt++;
                    if (active && b_cnt == n_bursts) nd = 1;
                end
                exp_done = nd;
                if (cmd_valid && cmd_ready) exp_busy = 1;
                if (nd) begin
                    exp_busy = 0;
                    active = 0;
                end
            end

            @(posedge clk);
            #2;
            s_data = pattern(src_idx);
            if (rst) begin
                awready = 0; wready = 0; s_valid = 0; bvalid = 0; bresp = 0;
            end else begin
                awready = rand_mode ? (($urandom % 3) != 0) : 1'b1;
                wready  = rand_mode ? (($urandom % 4) != 0) : 1'b1;
                s_valid = rand_mode ? (($urandom % 3) != 0) : 1'b1;
                bvalid  = !hold_b && (b_cnt < wl_cnt) && (rand_mode ? $urandom % 2 == 1 : 1'b1);
                bresp   = (bvalid && b_cnt == err_burst) ? 2'b10 : 2'b00;
            end
        end
    end

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input int beats);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        cmd_addr = a;
        cmd_beats = LW'(beats);
        cmd_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            n++;
            if (n >= 1000) begin
                chk("cmd_accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            n++;
            if (n >= limit) begin
                chk("done_timeout", 0, 1);
                break;
            end
        end
        settle();
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr = '0;
        cmd_beats = '0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;

        // Three bursts, the last one short.
        issue(32'h1000, 40);
        wait_done(2000);
        chk("t1_aw_count", 64'(log_n), 3);
        chk("t1_aw0_addr", 64'(log_aw_addr[0]), 64'h1000);
        chk("t1_aw0_len", 64'(log_aw_len[0]), 15);
        chk("t1_aw1_addr", 64'(log_aw_addr[1]), 64'h1040);
        chk("t1_aw1_len", 64'(log_aw_len[1]), 15);
        chk("t1_aw2_addr", 64'(log_aw_addr[2]), 64'h1080);
        chk("t1_aw2_len", 64'(log_aw_len[2]), 7);
        chk("t1_wlast_count", 64'(log_wl_n), 3);
        chk("t1_wlast0", 64'(log_wl_pos[0]), 16);
        chk("t1_wlast1", 64'(log_wl_pos[1]), 32);
        chk("t1_wlast2", 64'(log_wl_pos[2]), 40);
        chk("t1_done_after_b", 64'(done_cyc - lastb_cyc), 1);
        chk("t1_error", 64'(error), 0);

        // 4KB split.
        issue(32'h1FF0, 8);
        wait_done(2000);
        chk("t2_aw_count", 64'(log_n), 2);
        chk("t2_aw0_addr", 64'(log_aw_addr[0]), 64'h1FF0);
        chk("t2_aw0_len", 64'(log_aw_len[0]), 3);
        chk("t2_aw1_addr", 64'(log_aw_addr[1]), 64'h2000);
        chk("t2_aw1_len", 64'(log_aw_len[1]), 3);

        // Zero-beat command.
        issue(32'h3000, 0);
        wait_done(100);
        chk("t3_aw_count", 64'(log_n), 0);
        chk("t3_done_latency", 64'(done_cyc - acc_cyc), 2);
        chk("t3_busy_cycles", 64'(busy_cycles), 1);

        // Outstanding limit with B held off.
        hold_b = 1'b1;
        issue(32'h0, 96);
        repeat (200) @(negedge clk);
        #1;
        chk("t4_aw_count_held", 64'(log_n), 4);
        chk("t4_awvalid_held", 64'(awvalid), 0);
        hold_b = 1'b0;
        wait_done(2000);
        chk("t4_aw_count", 64'(log_n), 6);
        chk("t4_done_after_b", 64'(done_cyc - lastb_cyc), 1);

        // Error on the second of three bursts, sticky through done.
        err_burst = 1;
        issue(32'h2000, 40);
        wait_done(2000);
        err_burst = -1;
        chk("t5_error_at_done", 64'(error), 1);
        repeat (3) @(negedge clk);
        #1;
        chk("t5_error_held", 64'(error), 1);

        // Random back-pressure across a 4KB page; the next accept clears error.
        rand_mode = 1'b1;
        issue(32'h3F00, 100);
        settle();
        chk("t6_error_cleared", 64'(error), 0);
        wait_done(5000);
        rand_mode = 1'b0;
        chk("t6_aw_count", 64'(log_n), 7);
        chk("t6_aw4_addr", 64'(log_aw_addr[4]), 64'h4000);
        chk("t6_aw6_len", 64'(log_aw_len[6]), 3);

        // Reset in the middle of a data phase, then a clean command.
        issue(32'h0, 64);
        begin
            int n;
            n = 0;
            forever begin
                @(negedge clk);
                if (wvalid) break;
                n++;
                if (n >= 100) begin
                    chk("t7_wvalid_timeout", 0, 1);
                    break;
                end
            end
        end
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        settle();
        chk("t7_busy_after_rst", 64'(busy), 0);
        chk("t7_awvalid_after_rst", 64'(awvalid), 0);
        chk("t7_wvalid_after_rst", 64'(wvalid), 0);
        issue(32'h100, 20);
        wait_done(2000);
        chk("t7_aw_count", 64'(log_n), 2);
        chk("t7_aw1_len", 64'(log_aw_len[1]), 3);
        chk("t7_error", 64'(error), 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
